// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier. It uses a start/done handshake and runs one step per clock.
// Define SHIFT_ADD_SKIP_ZERO_EN to finish early once the remaining multiplier bits are all zero.
module shift_add_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   aclr_n,
   input  logic                   start,
   input  logic [WIDTH-1:0]       multiplicand,
   input  logic [WIDTH-1:0]       multiplier,
   output logic                   busy,
   output logic                   done,
   output logic [2*WIDTH-1:0]     product,
   output logic [$clog2(WIDTH):0] step_count
);

   localparam int SW = $clog2(WIDTH) + 1;
   localparam logic [SW-1:0] STEP_LAST = SW'(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t               state_reg, state_next;
   logic [2*WIDTH-1:0]   mcand_reg, mcand_next;
   logic [WIDTH-1:0]     mr_reg, mr_next;
   logic [2*WIDTH-1:0]   acc_reg, acc_next;
   logic [2*WIDTH-1:0]   product_reg, product_next;
   logic [SW-1:0]        step_reg, step_next;

   logic [2*WIDTH-1:0]   sum;
   logic [WIDTH-1:0]     mr_shift;
   logic [SW-1:0]        step_inc;
   logic                 last_step;

   always_ff @(posedge clk) begin
      if (!aclr_n) begin
         state_reg   <= ST_IDLE;
         mcand_reg   <= '0;
         mr_reg      <= '0;
         acc_reg     <= '0;
         product_reg <= '0;
         step_reg    <= '0;
      end else begin
         state_reg   <= state_next;
         mcand_reg   <= mcand_next;
         mr_reg      <= mr_next;
         acc_reg     <= acc_next;
         product_reg <= product_next;
         step_reg    <= step_next;
      end
   end

   // One step of the datapath, used only while running
   always_comb begin
      sum      = acc_reg + (mr_reg[0] ? mcand_reg : '0);
      mr_shift = mr_reg >> 1;
      step_inc = step_reg + 1'b1;
`ifdef SHIFT_ADD_SKIP_ZERO_EN
      last_step = (mr_shift == '0) || (step_inc == STEP_LAST);
`else
      last_step = (step_inc == STEP_LAST);
`endif
   end

   always_comb begin
      state_next   = state_reg;
      mcand_next   = mcand_reg;
      mr_next      = mr_reg;
      acc_next     = acc_reg;
      product_next = product_reg;
      step_next    = step_reg;
      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               mcand_next = {{WIDTH{1'b0}}, multiplicand};
               mr_next    = multiplier;
               acc_next   = '0;
               step_next  = '0;
               state_next = ST_RUN;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_RUN: begin
            acc_next   = sum;
            mcand_next = mcand_reg << 1;
            mr_next    = mr_shift;
            step_next  = step_inc;
            if (last_step) begin
               product_next = sum;
               state_next   = ST_DONE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign busy       = (state_reg == ST_RUN);
   assign done       = (state_reg == ST_DONE);
   assign product    = product_reg;
   assign step_count = step_reg;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed-vector bench for shift_add_multiplier (WIDTH=4); expected steps depend on SHIFT_ADD_SKIP_ZERO_EN.
module tb_shift_add_multiplier;

   localparam int WIDTH = 4;

   logic                   clk;
   logic                   aclr_n;
   logic                   start;
   logic [WIDTH-1:0]       multiplicand;
   logic [WIDTH-1:0]       multiplier;
   logic                   busy;
   logic                   done;
   logic [2*WIDTH-1:0]     product;
   logic [$clog2(WIDTH):0] step_count;

   int checks = 0;
   int errors = 0;

   shift_add_multiplier #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .aclr_n       (aclr_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product),
      .step_count   (step_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Call while the DUT is IDLE or DONE; returns in the DONE cycle.
   // poke > 0 raises start with other operands in that RUN cycle, which must be ignored.
   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp_p,
                         input int steps_full, input int steps_skip,
                         input logic [7:0] prev_p, input int poke);
      int edges;
      int exp_steps;
`ifdef SHIFT_ADD_SKIP_ZERO_EN
      exp_steps = steps_skip;
`else
      exp_steps = steps_full;
`endif
      multiplicand = a;
      multiplier   = b;
      start        = 1'b1;
      tick();
      start = 1'b0;
      edges = 1;
      while (!done && edges < 30) begin
         check("busy_in_run", 32'(busy), 32'd1);
         check("product_held", 32'(product), 32'(prev_p));
         if (edges == poke) begin
            start        = 1'b1;
            multiplicand = 4'd2;
            multiplier   = 4'd2;
         end else begin
            start = 1'b0;
         end
         tick();
         edges++;
      end
      start = 1'b0;
      check("latency_edges", 32'(edges), 32'(exp_steps + 1));
      check("done_high", 32'(done), 32'd1);
      check("busy_low_at_done", 32'(busy), 32'd0);
      check("product", 32'(product), 32'(exp_p));
      check("step_count", 32'(step_count), 32'(exp_steps));
      $display("op %0d x %0d -> product %0d steps %0d edges %0d", a, b, product, step_count, edges);
   endtask

   task automatic end_pulse(input logic [7:0] exp_p);
      tick();
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_not_busy", 32'(busy), 32'd0);
      check("product_kept", 32'(product), 32'(exp_p));
   endtask

   initial begin
      aclr_n       = 1'b0;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      tick();
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_product", 32'(product), 32'd0);
      check("rst_step", 32'(step_count), 32'd0);
      aclr_n = 1'b1;
      tick();

      run_op(4'd13, 4'd11, 8'd143, 4, 4, 8'd0, 0);
      end_pulse(8'd143);

      // Back-to-back: start sampled in the DONE cycle
      run_op(4'd15, 4'd15, 8'd225, 4, 4, 8'd143, 0);
      run_op(4'd3, 4'd5, 8'd15, 4, 3, 8'd225, 0);
      end_pulse(8'd15);

      // Start during RUN is ignored
      run_op(4'd9, 4'd6, 8'd54, 4, 3, 8'd15, 2);
      end_pulse(8'd54);

      // Reset mid-operation
      multiplicand = 4'd12;
      multiplier   = 4'd7;
      start        = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      aclr_n = 1'b0;
      tick();
      aclr_n = 1'b1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_product", 32'(product), 32'd0);
      check("abort_step", 32'(step_count), 32'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("abort_no_done", 32'(done), 32'd0);
      end
      $display("op 12 x 7 aborted by reset, product %0d", product);

      run_op(4'd4, 4'd4, 8'd16, 4, 3, 8'd0, 0);
      end_pulse(8'd16);
      run_op(4'd0, 4'd9, 8'd0, 4, 4, 8'd16, 0);
      end_pulse(8'd0);
      run_op(4'd9, 4'd0, 8'd0, 4, 1, 8'd0, 0);
      end_pulse(8'd0);
      run_op(4'd7, 4'd2, 8'd14, 4, 2, 8'd0, 0);
      end_pulse(8'd14);
      run_op(4'd5, 4'd0, 8'd0, 4, 1, 8'd14, 0);
      end_pulse(8'd0);
      run_op(4'd3, 4'd8, 8'd24, 4, 4, 8'd0, 0);
      end_pulse(8'd24);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
